// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mem_ctrl_pkg : state/owner encodings, transfer lengths and IO window base
// Rev 1.0
// ============================================================================
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_MEM  = 2'd2
   } owner_t;

   localparam logic [2:0]  LEN_B           = 3'b001;
   localparam logic [2:0]  LEN_H           = 3'b010;
   localparam logic [2:0]  LEN_W           = 3'b100;
   localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

   // Any length code other than byte/half collapses to a full word.
   function automatic logic [2:0] norm_len(input logic [2:0] len_code);
      case (len_code)
         LEN_B:   norm_len = LEN_B;
         LEN_H:   norm_len = LEN_H;
         default: norm_len = LEN_W;
      endcase
   endfunction

   function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
      case (idx)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// mem_ctrl : arbitrates IF/MEM requests onto a byte-wide RAM/IO bus
// Rev 1.0
// ============================================================================
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        if_enable_i,
   input  logic [31:0] if_addr_i,
   input  logic        if_clear_i,
   output logic        if_finished_o,
   output logic [31:0] if_data_o,
   input  logic        mem_enable_i,
   input  logic [31:0] mem_addr_i,
   input  logic [2:0]  mem_data_len_i,
   input  logic [31:0] mem_data_i,
   input  logic        mem_rw_sel_i,
   output logic        mem_finished_o,
   output logic [31:0] mem_data_o,
   output logic        if_busy_o,
   output logic        mem_busy_o,
   input  logic [7:0]  ram_din_i,
   output logic [7:0]  ram_dout_o,
   output logic [31:0] ram_a_o,
   output logic        ram_wr_o,
   input  logic        io_buffer_full_i
);

   state_t      state, state_nxt;
   owner_t      owner, owner_nxt;
   logic [2:0]  cnt, cnt_nxt;
   logic [2:0]  len, len_nxt;
   logic [31:0] addr, addr_nxt;
   logic [31:0] wdata, wdata_nxt;
   logic [31:0] asm_data, asm_nxt;
   logic [31:0] cur_addr;
   logic        io_hold;
   logic        fin;

   assign cur_addr = addr + {29'd0, cnt};
   assign io_hold  = (addr >= IO_BASE) && io_buffer_full_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         owner    <= OWN_NONE;
         cnt      <= 3'd0;
         len      <= 3'd0;
         addr     <= 32'd0;
         wdata    <= 32'd0;
         asm_data <= 32'd0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         cnt      <= cnt_nxt;
         len      <= len_nxt;
         addr     <= addr_nxt;
         wdata    <= wdata_nxt;
         asm_data <= asm_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      cnt_nxt    = cnt;
      len_nxt    = len;
      addr_nxt   = addr;
      wdata_nxt  = wdata;
      asm_nxt    = asm_data;
      ram_a_o    = 32'd0;
      ram_dout_o = 8'd0;
      ram_wr_o   = 1'b0;

      case (state)
         ST_IDLE: begin
            if (rdy) begin
               if (mem_enable_i) begin
                  addr_nxt  = mem_addr_i;
                  len_nxt   = norm_len(mem_data_len_i);
                  wdata_nxt = mem_data_i;
                  owner_nxt = OWN_MEM;
                  cnt_nxt   = 3'd0;
                  asm_nxt   = 32'd0;
                  state_nxt = mem_rw_sel_i ? ST_WRITE : ST_READ;
               end else if (if_enable_i && !if_clear_i) begin
                  addr_nxt  = if_addr_i;
                  len_nxt   = LEN_W;
                  owner_nxt = OWN_IF;
                  cnt_nxt   = 3'd0;
                  asm_nxt   = 32'd0;
                  state_nxt = ST_READ;
               end
            end
         end

         ST_READ: begin
            // cnt counts addresses issued; byte cnt-1 is on ram_din_i this cycle.
            // While stalled, re-drive the address of the byte still to be
            // captured so ram_din_i carries it when rdy returns.
            if (!rdy) begin
               ram_a_o = (cnt != 3'd0) ? (cur_addr - 32'd1) : cur_addr;
            end else if ((owner == OWN_IF) && if_clear_i) begin
               state_nxt = ST_IDLE;
               owner_nxt = OWN_NONE;
               cnt_nxt   = 3'd0;
            end else begin
               if (cnt < len) begin
                  ram_a_o = cur_addr;
               end
               case (cnt)
                  3'd1:    asm_nxt[7:0]   = ram_din_i;
                  3'd2:    asm_nxt[15:8]  = ram_din_i;
                  3'd3:    asm_nxt[23:16] = ram_din_i;
                  3'd4:    asm_nxt[31:24] = ram_din_i;
                  default: asm_nxt        = asm_data;
               endcase
               if (cnt == len) begin
                  state_nxt = ST_DONE;
                  cnt_nxt   = 3'd0;
               end else begin
                  cnt_nxt = cnt + 3'd1;
               end
            end
         end

         ST_WRITE: begin
            ram_a_o    = cur_addr;
            ram_dout_o = byte_sel(wdata, cnt[1:0]);
            if (rdy && !io_hold) begin
               ram_wr_o = 1'b1;
               if (cnt == (len - 3'd1)) begin
                  state_nxt = ST_DONE;
                  cnt_nxt   = 3'd0;
               end else begin
                  cnt_nxt = cnt + 3'd1;
               end
            end
         end

         default: begin
            if (rdy) begin
               state_nxt = ST_IDLE;
               owner_nxt = OWN_NONE;
            end
         end
      endcase
   end

   assign fin            = (state == ST_DONE) && rdy;
   assign if_finished_o  = fin && (owner == OWN_IF);
   assign mem_finished_o = fin && (owner == OWN_MEM);
   assign if_data_o      = if_finished_o  ? asm_data : 32'd0;
   assign mem_data_o     = mem_finished_o ? asm_data : 32'd0;
   assign if_busy_o      = (owner == OWN_IF);
   assign mem_busy_o     = (owner == OWN_MEM);

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_ctrl : directed table, corner sequences and random traffic vs. a
// byte-array memory model. Rev 1.0
// ============================================================================
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b0;
   logic        if_enable = 1'b0;
   logic [31:0] if_addr = 32'd0;
   logic        if_clear = 1'b0;
   logic        if_fin;
   logic [31:0] if_data;
   logic        mem_enable = 1'b0;
   logic [31:0] mem_addr = 32'd0;
   logic [2:0]  mem_len = 3'd0;
   logic [31:0] mem_wdata = 32'd0;
   logic        mem_rw = 1'b0;
   logic        mem_fin;
   logic [31:0] mem_data;
   logic        if_busy, mem_busy;
   logic [7:0]  ram_din = 8'd0;
   logic [7:0]  ram_dout;
   logic [31:0] ram_a;
   logic        ram_wr;
   logic        io_full = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_ctrl dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .if_enable_i(if_enable), .if_addr_i(if_addr), .if_clear_i(if_clear),
      .if_finished_o(if_fin), .if_data_o(if_data),
      .mem_enable_i(mem_enable), .mem_addr_i(mem_addr), .mem_data_len_i(mem_len),
      .mem_data_i(mem_wdata), .mem_rw_sel_i(mem_rw),
      .mem_finished_o(mem_fin), .mem_data_o(mem_data),
      .if_busy_o(if_busy), .mem_busy_o(mem_busy),
      .ram_din_i(ram_din), .ram_dout_o(ram_dout), .ram_a_o(ram_a), .ram_wr_o(ram_wr),
      .io_buffer_full_i(io_full)
   );

   // ---------------- memory contents: bus RAM and reference model ----------
   logic [7:0] ram_mem   [logic [31:0]];
   logic [7:0] model_mem [logic [31:0]];

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      case (a)
         32'h100:  return 8'h13;
         32'h101:  return 8'h05;
         32'h102:  return 8'h00;
         32'h103:  return 8'h00;
         32'h1000: return 8'h11;
         32'h1001: return 8'h22;
         32'h1002: return 8'h33;
         32'h1003: return 8'h44;
         default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
      endcase
   endfunction

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      return ram_mem.exists(a) ? ram_mem[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] model_rd(input logic [31:0] a);
      return model_mem.exists(a) ? model_mem[a] : init_byte(a);
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] a, input logic [2:0] l);
      logic [31:0] w;
      w = 32'd0;
      for (int i = 0; i < int'(l); i++) w[8*i +: 8] = model_rd(a + i);
      return w;
   endfunction

   // Bus RAM: address sampled mid-cycle, data returned the following cycle.
   logic [31:0] a_q = 32'd0;
   logic [7:0]  dout_q = 8'd0;
   logic        wr_q = 1'b0;
   int          wr_cnt = 0, wr_full_cnt = 0, if_fin_cnt = 0, mem_fin_cnt = 0;
   logic [31:0] last_wa = 32'd0;
   logic [7:0]  last_wd = 8'd0;

   always @(negedge clk) begin
      a_q    = ram_a;
      wr_q   = ram_wr;
      dout_q = ram_dout;
      if (ram_wr) begin
         wr_cnt++;
         last_wa = ram_a;
         last_wd = ram_dout;
         if (io_full) wr_full_cnt++;
      end
      if (if_fin)  if_fin_cnt++;
      if (mem_fin) mem_fin_cnt++;
   end

   always @(posedge clk) begin
      ram_din <= ram_rd(a_q);
      if (wr_q) ram_mem[a_q] = dout_q;
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] all_outs();
      return {19'd0, if_fin, if_data, mem_fin, mem_data, if_busy, mem_busy, ram_dout, ram_a, ram_wr};
   endfunction

   // Called at posedge+1 of an idle cycle (cycle 0); returns at posedge+1 of
   // the idle cycle following DONE. cyc = -1 on timeout.
   task automatic run_req(input bit is_if, input logic [31:0] a, input logic [2:0] l,
                          input logic [31:0] wd, input bit rw,
                          input int rs, input int rl, input int fs, input int fl,
                          output int cyc, output logic [31:0] d);
      bit done;
      if (is_if) begin
         if_enable = 1'b1; if_addr = a;
      end else begin
         mem_enable = 1'b1; mem_addr = a; mem_len = l; mem_wdata = wd; mem_rw = rw;
      end
      cyc  = 0;
      d    = 32'd0;
      done = 1'b0;
      while (!done) begin
         @(posedge clk); #1;
         cyc++;
         rdy     = !(rl > 0 && cyc >= rs && cyc < rs + rl);
         io_full = (fl > 0 && cyc >= fs && cyc < fs + fl);
         #1;
         if (is_if ? if_fin : mem_fin) begin
            d    = is_if ? if_data : mem_data;
            done = 1'b1;
         end else if (cyc >= 60) begin
            cyc  = -1;
            done = 1'b1;
         end
      end
      if_enable = 1'b0; mem_enable = 1'b0; rdy = 1'b1; io_full = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_txn(input string nm, input bit is_if, input logic [31:0] a,
                         input logic [2:0] l, input logic [31:0] wd, input bit rw,
                         input int rs, input int rl, input int fs, input int fl,
                         input int exp_cyc, input logic [31:0] exp_d);
      int          cyc, wr0, full0;
      logic [31:0] d, sh;
      wr0   = wr_cnt;
      full0 = wr_full_cnt;
      run_req(is_if, a, l, wd, rw, rs, rl, fs, fl, cyc, d);
      check({nm, " latency"}, cyc, exp_cyc);
      if (rw) begin
         sh = wd >> (8 * (l - 1));
         check({nm, " strobes"}, wr_cnt - wr0, l);
         check({nm, " last addr"}, last_wa, a + l - 1);
         check({nm, " last byte"}, last_wd, sh[7:0]);
         if (fl > 0) check({nm, " strobes while full"}, wr_full_cnt - full0, 0);
         for (int i = 0; i < int'(l); i++) model_mem[a + i] = wd[8*i +: 8];
      end else begin
         check({nm, " data"}, d, exp_d);
      end
   endtask

   typedef struct {
      string       name;
      bit          is_if;
      logic [31:0] a;
      logic [2:0]  l;
      logic [31:0] wd;
      bit          rw;
      logic [31:0] exp_d;
      int          exp_cyc;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int          f_if0, f_mem0, mcyc, icyc, k, l, cyc;
      logic [31:0] md, idat, a, wd;

      tbl[0] = '{"if fetch 0x100", 1'b1, 32'h100,  3'd4, 32'h0,          1'b0, 32'h0000_0513, 6};
      tbl[1] = '{"lw 0x1000",      1'b0, 32'h1000, 3'd4, 32'h0,          1'b0, 32'h4433_2211, 6};
      tbl[2] = '{"lh 0x1002",      1'b0, 32'h1002, 3'd2, 32'h0,          1'b0, 32'h0000_4433, 4};
      tbl[3] = '{"lb 0x1001",      1'b0, 32'h1001, 3'd1, 32'h0,          1'b0, 32'h0000_0022, 3};
      tbl[4] = '{"sb 0x2003",      1'b0, 32'h2003, 3'd1, 32'hAABB_CCDD,  1'b1, 32'h0,         2};
      tbl[5] = '{"lb 0x2003",      1'b0, 32'h2003, 3'd1, 32'h0,          1'b0, 32'h0000_00DD, 3};
      tbl[6] = '{"sh 0x2010",      1'b0, 32'h2010, 3'd2, 32'h1234_5678,  1'b1, 32'h0,         3};
      tbl[7] = '{"lh 0x2010",      1'b0, 32'h2010, 3'd2, 32'h0,          1'b0, 32'h0000_5678, 4};
      tbl[8] = '{"sw 0x2020",      1'b0, 32'h2020, 3'd4, 32'hCAFE_F00D,  1'b1, 32'h0,         5};
      tbl[9] = '{"lw 0x2020",      1'b0, 32'h2020, 3'd4, 32'h0,          1'b0, 32'hCAFE_F00D, 6};

      repeat (3) @(posedge clk);
      #1;
      check("outputs during reset", all_outs(), 128'd0);
      rst = 1'b0;
      rdy = 1'b1;
      @(posedge clk); #1;
      check("outputs after reset", all_outs(), 128'd0);

      for (int i = 0; i < 10; i++)
         do_txn(tbl[i].name, tbl[i].is_if, tbl[i].a, tbl[i].l, tbl[i].wd, tbl[i].rw,
                0, 0, 0, 0, tbl[i].exp_cyc, tbl[i].exp_d);

      // Simultaneous IF and MEM: MEM first, IF accepted the cycle after DONE.
      f_if0  = if_fin_cnt;
      f_mem0 = mem_fin_cnt;
      mcyc = -1; icyc = -1; md = 32'd0; idat = 32'd0;
      mem_enable = 1'b1; mem_addr = 32'h1000; mem_len = 3'd4; mem_rw = 1'b0;
      if_enable  = 1'b1; if_addr  = 32'h100;
      for (int c = 1; c <= 40 && icyc < 0; c++) begin
         @(posedge clk); #1;
         if (c == 1) check("arb mem busy", {if_busy, mem_busy}, 2'b01);
         if (c == 8) check("arb if busy", {if_busy, mem_busy}, 2'b10);
         if (mem_fin) begin mcyc = c; md = mem_data; mem_enable = 1'b0; end
         if (if_fin)  begin icyc = c; idat = if_data; if_enable = 1'b0; end
      end
      if_enable = 1'b0; mem_enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("arb mem latency", mcyc, 6);
      check("arb mem data", md, 32'h4433_2211);
      check("arb if latency", icyc, 13);
      check("arb if data", idat, 32'h0000_0513);
      check("arb finished pulses", {if_fin_cnt - f_if0, mem_fin_cnt - f_mem0}, {32'd1, 32'd1});

      // IO store held three cycles on byte 1.
      do_txn("sw io stall", 1'b0, 32'h0003_0000, 3'd4, 32'h8765_4321, 1'b1, 0, 0, 2, 3, 8, 32'h0);
      do_txn("lw io readback", 1'b0, 32'h0003_0000, 3'd4, 32'h0, 1'b0, 0, 0, 0, 0, 6, 32'h8765_4321);

      // IF abort in cycle 3.
      f_if0 = if_fin_cnt;
      if_enable = 1'b1; if_addr = 32'h1000;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (c == 3) begin
            if_clear = 1'b1;
            #1;
            check("clear ram_a", ram_a, 32'd0);
         end
         if (c == 4) begin
            if_clear = 1'b0; if_enable = 1'b0;
            check("clear idle busy", {if_busy, mem_busy}, 2'b00);
         end
      end
      check("clear no finished", if_fin_cnt - f_if0, 0);
      do_txn("lh after clear", 1'b0, 32'h1000, 3'd2, 32'h0, 1'b0, 0, 0, 0, 0, 4, 32'h0000_2211);

      // rdy low two cycles mid-load.
      do_txn("lw rdy stall", 1'b0, 32'h1000, 3'd4, 32'h0, 1'b0, 3, 2, 0, 0, 8, 32'h4433_2211);

      // Reset in cycle 2 of a word store: only byte 0 reached the bus.
      f_mem0 = mem_fin_cnt;
      mem_enable = 1'b1; mem_addr = 32'h2040; mem_len = 3'd4; mem_wdata = 32'h0102_0304; mem_rw = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1 check("async reset outputs", all_outs(), 128'd0);
      mem_enable = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("reset no finished", {mem_fin_cnt - f_mem0, 30'd0, if_busy, mem_busy}, 64'd0);
      model_mem[32'h2040] = 8'h04;
      do_txn("lw after reset", 1'b0, 32'h2040, 3'd4, 32'h0, 1'b0, 0, 0, 0, 0, 6, model_word(32'h2040, 3'd4));

      // Random traffic against the byte-array model.
      for (int n = 0; n < 40; n++) begin
         k = $urandom_range(0, 6);
         l = (k % 3 == 1) ? 1 : (k % 3 == 2) ? 2 : 4;
         if (k == 0) begin
            a = 32'h1000 + 4 * $urandom_range(0, 15);
            do_txn("rand if", 1'b1, a, 3'd4, 32'h0, 1'b0, 0, 0, 0, 0, 6, model_word(a, 3'd4));
         end else begin
            a = ($urandom_range(0, 3) == 0) ? 32'h0003_0000 + $urandom_range(0, 15)
                                            : 32'h1000 + $urandom_range(0, 63);
            if (k <= 3) begin
               do_txn("rand load", 1'b0, a, 3'(l), 32'h0, 1'b0, 0, 0, 0, 0, l + 2, model_word(a, 3'(l)));
            end else begin
               wd = $urandom;
               do_txn("rand store", 1'b0, a, 3'(l), wd, 1'b1, 0, 0, 0, 0, l + 1, 32'h0);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller between the CPU core and the byte-wide RAM/IO bus. Arbitrates the instruction-fetch requester (IF) and the load/store requester (MEM) and serialises each request into 1, 2 or 4 byte-cycles. Assembles little-endian read data and returns it with a one-cycle `finished` pulse per requester. Sits below IF and MEM, directly on the RAM pins.

## Interface
Parameters:
- IO_BASE, 32'h0003_0000: addresses ≥ IO_BASE are IO-mapped and subject to `io_buffer_full_i` back-pressure.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global ready; low freezes all state
- if_enable_i  in  1  IF read request, level, held until `if_finished_o`
- if_addr_i  in  32  IF word address
- if_clear_i  in  1  abort the pending/active IF read (branch redirect)
- if_finished_o  out  1  one-cycle pulse, `if_data_o` valid
- if_data_o  out  32  fetched instruction word
- mem_enable_i  in  1  MEM request, level, held until `mem_finished_o`
- mem_addr_i  in  32  byte address
- mem_data_len_i  in  3  bytes to transfer: 3'b001, 3'b010, 3'b100
- mem_data_i  in  32  store data, low bytes used
- mem_rw_sel_i  in  1  0 = load, 1 = store
- mem_finished_o  out  1  one-cycle pulse, load data valid / store complete
- mem_data_o  out  32  load data, zero-extended to 32 bits
- if_busy_o  out  1  controller is serving IF
- mem_busy_o  out  1  controller is serving MEM
- ram_din_i  in  8  RAM read byte, returns 1 cycle after `ram_a_o`
- ram_dout_o  out  8  RAM write byte
- ram_a_o  out  32  RAM byte address
- ram_wr_o  out  1  1 = write `ram_dout_o` at `ram_a_o`
- io_buffer_full_i  in  1  IO write buffer full

## Operation
- States: IDLE, READ, WRITE, DONE. Owner register: NONE/IF/MEM. Byte counter `cnt` (0..4), length `len`.
- IDLE: if `mem_enable_i` → latch addr/len/data/rw, owner = MEM, go READ or WRITE. Else if `if_enable_i` and not `if_clear_i` → owner = IF, len = 4, go READ. MEM wins simultaneous requests.
- READ: cycle k (k = 0 .. len-1 after entry) drives `ram_a_o` = addr + k; cycle k+1 captures `ram_din_i` into byte k of the assembly register. After capturing byte len-1 → DONE.
- WRITE: cycle k drives addr + k, `ram_dout_o` = data byte k, `ram_wr_o` = 1. After byte len-1 → DONE. If addr ≥ IO_BASE and `io_buffer_full_i` = 1, hold the current byte with `ram_wr_o` = 0 and do not advance.
- DONE: pulse the owner's `finished`, present data, owner = NONE, return to IDLE. No request is accepted in DONE, since requesters drop `enable` in that cycle.
- `if_clear_i` while owner = IF, in READ: go to IDLE next edge, no `if_finished_o`, `ram_a_o` = 0. It never aborts MEM.
- `mem_data_o` bytes ≥ len are zero; sign extension is the MEM stage's job.
- `rdy` = 0: state, counter and address hold, `ram_wr_o` forced 0; the held address keeps `ram_din_i` valid for capture on resume.
- `if_busy_o` / `mem_busy_o` = owner decode, combinational.

## Timing
- Reset values: state IDLE, owner NONE, cnt 0, all outputs 0 (`ram_a_o` = 0, `ram_wr_o` = 0, finished 0, data 0, busy 0).
- Cycle 0 = request sampled in IDLE.
- Read of len N: addresses in cycles 1..N, bytes in cycles 2..N+1, `finished` in cycle N+2. An IF fetch is 6 cycles.
- Write of len N: `ram_wr_o` in cycles 1..N, `finished` in cycle N+1.
- Back-to-back requests: the earliest next acceptance is the cycle after DONE.
- `ram_a_o` = 0 and `ram_wr_o` = 0 whenever the state is not READ or WRITE.
- Reset mid-transfer: immediate return to reset values, transfer discarded, no `finished`.

## Structure
- Add to config.v: state encodings, owner encodings, length constants LEN_B/LEN_H/LEN_W (3'b001/010/100), and IO_BASE.
- Single module. No sub-module; byte assembly and steering are a small 4:1 mux / decoder kept inline.

## Test plan
- IF fetch addr 0x0000_0100, RAM bytes 13,05,00,00 → `if_finished_o` in cycle 6, `if_data_o` = 0x0000_0513.
- IF and MEM load (LW, 0x1000) requested together → MEM served first (`mem_busy_o` = 1), then IF. Each gets exactly one `finished`.
- SB 0x0000_2003, data 0xAABBCCDD → one cycle with `ram_wr_o` = 1, `ram_a_o` = 0x2003, `ram_dout_o` = 0xDD. `mem_finished_o` in cycle 2.
- SW to 0x0003_0000 with `io_buffer_full_i` high for 3 cycles during byte 1 → byte 1 held, no write strobes while full, `finished` delayed by 3 cycles.
- `if_clear_i` in cycle 3 of an IF fetch → IDLE next cycle, no `if_finished_o`; a following MEM LH is accepted normally.
- `rdy` low for 2 cycles mid-LW, and `rst` asserted mid-SW → LW data correct and 2 cycles late. Reset forces all outputs to 0 asynchronously, no `finished`.
